// File: rtl/chess_turn_clock_if.sv
// Board-side signal bundle for the chess game clock: move/control inputs in,
// time displays and game status out.
interface chess_turn_clock_if #(
  parameter int TIME_WIDTH = 10
);
  logic                  StartGame;
  logic                  Pause;
  logic                  Player;
  logic [1:0]            Checkmate;
  logic [TIME_WIDTH-1:0] WhiteSeconds;
  logic [TIME_WIDTH-1:0] BlackSeconds;
  logic                  ActivePlayer;
  logic                  Running;
  logic                  GameOver;
  logic [1:0]            Timeout;

  modport master (
    output StartGame, Pause, Player, Checkmate,
    input  WhiteSeconds, BlackSeconds, ActivePlayer, Running, GameOver, Timeout
  );

  modport slave (
    input  StartGame, Pause, Player, Checkmate,
    output WhiteSeconds, BlackSeconds, ActivePlayer, Running, GameOver, Timeout
  );
endinterface

// File: rtl/chess_turn_clock.sv
// Chess game clock: per-side countdown with pause, turn tracking, timeout and checkmate.
// Optional per-move bonus time is enabled by defining CHESS_INCREMENT_EN.
//
// state    | meaning
// IDLE     | after reset, waiting for StartGame
// RUNNING  | charging the active side once per TICKS_PER_SEC cycles
// PAUSED   | countdown frozen, tick count held
// FINISHED | flag fell or checkmate; times frozen until StartGame
module chess_turn_clock #(
  parameter int TICKS_PER_SEC     = 5,
  parameter int INIT_SECONDS      = 300,
  parameter int TIME_WIDTH        = 10,
  parameter int INCREMENT_SECONDS = 2
) (
  input  logic               OutClock,
  input  logic               resetApp,
  chess_turn_clock_if.slave  bus
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TIME_WIDTH-1:0] INIT_T    = TIME_WIDTH'(INIT_SECONDS);

  if (TICKS_PER_SEC < 1 || INIT_SECONDS >= 2**TIME_WIDTH || INCREMENT_SECONDS < 0) begin : g_bad_params
    $error("chess_turn_clock: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_FINISHED
  } state_t;

  state_t                state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [TIME_WIDTH-1:0] white_q, white_d;
  logic [TIME_WIDTH-1:0] black_q, black_d;
  logic                  active_q, active_d;
  logic                  prev_player_q, prev_player_d;
  logic [1:0]            timeout_q, timeout_d;
  logic                  running_q, running_d;
  logic                  game_over_q, game_over_d;

  logic                  wrap;
  logic                  flag_fell;
  logic                  unused_winner;

  // The winner of a checkmate is reported by the board itself, not by this block.
  assign unused_winner = bus.Checkmate[1];

  function automatic logic [TIME_WIDTH-1:0] dec_sat(input logic [TIME_WIDTH-1:0] s);
    return (s == '0) ? '0 : s - TIME_WIDTH'(1);
  endfunction

`ifdef CHESS_INCREMENT_EN
  function automatic logic [TIME_WIDTH-1:0] add_bonus(input logic [TIME_WIDTH-1:0] s);
    logic [31:0] sum;
    sum = 32'(s) + 32'(INCREMENT_SECONDS);
    return (sum > 32'(2**TIME_WIDTH - 1)) ? '1 : sum[TIME_WIDTH-1:0];
  endfunction
`endif

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    white_d       = white_q;
    black_d       = black_q;
    active_d      = active_q;
    timeout_d     = timeout_q;
    prev_player_d = bus.Player;
    wrap          = 1'b0;
    flag_fell     = 1'b0;

    case (state_q)
      ST_IDLE, ST_FINISHED: begin
        if (bus.StartGame) begin
          state_d   = ST_RUNNING;
          white_d   = INIT_T;
          black_d   = INIT_T;
          tick_d    = '0;
          active_d  = bus.Player;
          timeout_d = 2'b00;
        end
      end

      ST_RUNNING, ST_PAUSED: begin
        if (bus.Checkmate[0]) begin
          state_d = ST_FINISHED;
        end else begin
          if (state_q == ST_RUNNING) begin
            wrap   = (tick_q == TICK_LAST);
            tick_d = wrap ? '0 : tick_q + TICK_W'(1);
          end
          if (wrap) begin
            if (active_q) begin
              flag_fell = (white_q == TIME_WIDTH'(1));
              white_d   = dec_sat(white_q);
            end else begin
              flag_fell = (black_q == TIME_WIDTH'(1));
              black_d   = dec_sat(black_q);
            end
          end

          if (flag_fell) begin
            timeout_d = {~active_q, 1'b1};
            state_d   = ST_FINISHED;
          end else begin
            // The second just completed stays charged to the old side; bonus lands on top.
            if (bus.Player != prev_player_q) begin
              active_d = bus.Player;
              tick_d   = '0;
`ifdef CHESS_INCREMENT_EN
              if (active_q) white_d = add_bonus(white_d);
              else          black_d = add_bonus(black_d);
`endif
            end
            if (state_q == ST_RUNNING && bus.Pause)      state_d = ST_PAUSED;
            else if (state_q == ST_PAUSED && !bus.Pause) state_d = ST_RUNNING;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    running_d   = (state_d == ST_RUNNING);
    game_over_d = (state_d == ST_FINISHED);
  end

  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      state_q       <= ST_IDLE;
      tick_q        <= '0;
      white_q       <= INIT_T;
      black_q       <= INIT_T;
      active_q      <= 1'b1;
      prev_player_q <= 1'b0;
      timeout_q     <= 2'b00;
      running_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      white_q       <= white_d;
      black_q       <= black_d;
      active_q      <= active_d;
      prev_player_q <= prev_player_d;
      timeout_q     <= timeout_d;
      running_q     <= running_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.WhiteSeconds = white_q;
  assign bus.BlackSeconds = black_q;
  assign bus.ActivePlayer = active_q;
  assign bus.Running      = running_q;
  assign bus.GameOver     = game_over_q;
  assign bus.Timeout      = timeout_q;

endmodule
